// File: rtl/siso_pkg.sv
// Shared definitions for the serial-in/serial-out frame controller.
// Holds the default frame width and the controller state encoding.
package siso_pkg;

    localparam int unsigned SISO_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } siso_state_e;

endpackage

// File: rtl/siso_shreg.sv
// Serial datapath: parallel-load shift register with selectable bit order.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   i_load       - load i_load_data / i_load_msb (priority over shift)
//   i_load_data  - parallel word
//   i_load_msb   - 1: present MSB first, 0: present LSB first
//   i_en         - advance to the next bit
//   o_bit        - bit currently presented
module siso_shreg
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH = SISO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_load_msb,
    input  logic             i_en,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_data;
    logic             r_msb;

    // Load has priority; shifting moves the next bit into the output position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_msb  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_msb  <= i_load_msb;
        end else if (i_en) begin
            if (r_msb) r_data <= {r_data[WIDTH-2:0], 1'b0};
            else       r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign o_bit = r_msb ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/siso_ctrl.sv
// Frame controller: accepts a parallel word and presents it one bit per
// cycle on o, with hold (pause), abort (cancel) and a one-cycle done pulse.
// Ports:
//   clk, rst             - clock, async active-low reset
//   in_valid/in_ready    - word handshake (in_ready = IDLE & ~abort)
//   in_data, msb_first   - word and bit order, captured at acceptance
//   hold                 - pause; sampled at the edge, gates the following cycle
//   abort                - cancel frame in SHIFT, block acceptance in IDLE
//   o, o_en              - serial bit and its qualifier
//   busy, done           - frame in progress, end-of-frame pulse
module siso_ctrl
    import siso_pkg::*;
#(
    parameter int unsigned WIDTH = SISO_DEF_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    input  logic             hold,
    input  logic             abort,
    output logic             o,
    output logic             o_en,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    siso_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_o_en, w_o_en_nxt;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_load_msb;
    logic             w_shift;
    logic             w_bit;

    // Acceptance only outside reset, in IDLE, and without abort.
    assign in_ready = rst & ~abort & (r_state == ST_IDLE);
    assign w_accept = in_valid & in_ready;

    // State, bit counter and registered o_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_o_en  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_o_en  <= w_o_en_nxt;
        end
    end

    // Next state. The counter only advances out of a cycle whose bit was
    // actually valid (r_o_en), so a held bit is re-presented once hold drops.
    // Leaving a frame reloads the shift register with zeros to discard the word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_o_en_nxt  = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_msb  = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                    w_load_data = in_data;
                    w_load_msb  = msb_first;
                    w_o_en_nxt  = ~hold;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end else if (r_o_en) begin
                    if (r_cnt == LAST_BIT) begin
                        w_state_nxt = ST_DONE;
                        w_load      = 1'b1;
                    end else begin
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                        w_shift    = 1'b1;
                        w_o_en_nxt = ~hold;
                    end
                end else begin
                    w_o_en_nxt = ~hold;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    siso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_load_msb  (w_load_msb),
        .i_en        (w_shift),
        .o_bit       (w_bit)
    );

    assign o    = w_bit & (r_state == ST_SHIFT);
    assign o_en = r_o_en;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_siso_ctrl.sv
// Self-checking bench for siso_ctrl: directed scenarios plus randomized
// frames against a queue-based per-cycle reference model.
module tb_siso_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         msb_first = 1'b0;
    logic         hold = 1'b0;
    logic         abort = 1'b0;
    logic         o, o_en, busy, done;

    int n_err = 0;
    int n_chk = 0;

    // Expected {busy, done, o_en, o, in_ready} per cycle, and per-cycle hold.
    logic [4:0] exp_q[$];
    bit         hold_q[$];

    siso_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .msb_first (msb_first),
        .hold      (hold),
        .abort     (abort),
        .o         (o),
        .o_en      (o_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: word accepted in cycle 0; bits leave a queue one per
    // un-held cycle (hold seen at an edge pauses the next cycle); an empty
    // queue yields one done cycle; abort drops the frame.
    function automatic void model(input logic [W-1:0] word, input logic msb,
                                  input int abort_c, input int n);
        logic bits[$];
        bit   in_frame, show_done, live, ab;
        in_frame  = 1'b0;
        show_done = 1'b0;
        live      = 1'b0;
        exp_q.delete();
        for (int i = 0; i < int'(W); i++) bits.push_back(msb ? word[int'(W)-1-i] : word[i]);
        for (int c = 0; c < n; c++) begin
            ab = (c == abort_c);
            if (c == 0) begin
                exp_q.push_back({4'b0000, 1'b1});
                in_frame = 1'b1;
                live     = !hold_q[0];
            end else if (in_frame) begin
                exp_q.push_back({1'b1, 1'b0, live, bits[0], 1'b0});
                if (ab) in_frame = 1'b0;
                else if (live) begin
                    void'(bits.pop_front());
                    if (bits.size() == 0) begin
                        in_frame  = 1'b0;
                        show_done = 1'b1;
                    end
                end
                if (in_frame) live = !hold_q[c];
            end else if (show_done) begin
                exp_q.push_back(5'b11000);
                show_done = 1'b0;
            end else begin
                exp_q.push_back({4'b0000, !ab});
            end
        end
    endfunction

    task automatic clear_hold(input int n);
        hold_q.delete();
        repeat (n) hold_q.push_back(1'b0);
    endtask

    // Drive one cycle's inputs (just after a rising edge), sample at the falling edge.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic m,
                       input logic h, input logic a, output logic [4:0] obs);
        in_valid = v; in_data = d; msb_first = m; hold = h; abort = a;
        @(negedge clk);
        obs = {busy, done, o_en, o, in_ready};
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #2;
        n_chk++;
        if ({busy, done, o_en, o, in_ready} !== 5'b00000) begin
            n_err++; $display("FAIL reset_async: got %b want 00000", {busy, done, o_en, o, in_ready});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({busy, done, o_en, o, in_ready} !== 5'b00000) begin
            n_err++; $display("FAIL reset_held: got %b want 00000", {busy, done, o_en, o, in_ready});
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, o_en, o, in_ready} !== 5'b00001) begin
            n_err++; $display("FAIL reset_release: got %b want 00001", {busy, done, o_en, o, in_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_msb_first;
        logic [4:0] obs; logic [W-1:0] got; int nb;
        got = '0; nb = 0;
        clear_hold(12); model(8'hA5, 1'b1, -1, 12);
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, (c == 0) ? 8'hA5 : W'($urandom), (c == 0) ? 1'b1 : 1'($urandom), 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL msb_first c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[2]) begin got = {got[W-2:0], obs[1]}; nb++; end
        end
        n_chk++;
        if (got !== 8'hA5 || nb != 8) begin
            n_err++; $display("FAIL msb_first_word: got %h/%0d bits want a5/8", got, nb);
        end
    endtask

    task automatic test_lsb_first;
        logic [4:0] obs; logic [W-1:0] got; int nb;
        got = '0; nb = 0;
        clear_hold(12); model(8'hA5, 1'b0, -1, 12);
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, (c == 0) ? 8'hA5 : W'($urandom), (c == 0) ? 1'b0 : 1'($urandom), 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL lsb_first c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[2]) begin got = {obs[1], got[W-1:1]}; nb++; end
        end
        n_chk++;
        if (got !== 8'hA5 || nb != 8) begin
            n_err++; $display("FAIL lsb_first_word: got %h/%0d bits want a5/8", got, nb);
        end
    endtask

    task automatic test_hold;
        logic [4:0] obs; logic [W-1:0] got; int done_c;
        got = '0; done_c = -1;
        clear_hold(15);
        for (int c = 3; c <= 5; c++) hold_q[c] = 1'b1;
        model(8'hF0, 1'b1, -1, 15);
        for (int c = 0; c < 15; c++) begin
            cyc(c == 0, (c == 0) ? 8'hF0 : W'($urandom), (c == 0) ? 1'b1 : 1'($urandom), hold_q[c], 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL hold c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[2]) got = {got[W-2:0], obs[1]};
            if (obs[3]) done_c = c;
        end
        n_chk++;
        if (got !== 8'hF0 || done_c != 12) begin
            n_err++; $display("FAIL hold_result: got %h done@%0d want f0 done@12", got, done_c);
        end
    endtask

    task automatic test_abort;
        logic [4:0] obs; int dones;
        dones = 0;
        clear_hold(9); model(8'h3C, 1'b1, 5, 9);
        for (int c = 0; c < 9; c++) begin
            cyc(c == 0, 8'h3C, 1'b1, 1'b0, c == 5, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL abort_shift c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[3]) dones++;
        end
        n_chk++;
        if (dones != 0) begin
            n_err++; $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
        end
        // Abort in IDLE blocks acceptance.
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, obs);
        n_chk++;
        if (obs !== 5'b00000) begin
            n_err++; $display("FAIL abort_idle_ready: got %b want 00000", obs);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, obs);
        n_chk++;
        if (obs !== 5'b00001) begin
            n_err++; $display("FAIL abort_idle_noaccept: got %b want 00001", obs);
        end
        // Abort in DONE is ignored.
        clear_hold(12); model(8'h5A, 1'b0, 9, 12);
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, 8'h5A, 1'b0, 1'b0, c == 9, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL abort_done c%0d: got %b want %b", c, obs, exp_q[c]);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [4:0] obs; logic [W-1:0] lw, got;
        lw = 8'h6B; got = '0;
        clear_hold(6); model(lw, 1'b1, -1, 6);
        for (int c = 0; c < 6; c++) begin
            cyc(c == 0, lw, 1'b1, 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL arst_pre c%0d: got %b want %b", c, obs, exp_q[c]);
            end
        end
        in_valid = 1'b0;
        #2;
        n_chk++;
        if (o_en !== 1'b1 || o !== lw[W-1-5]) begin
            n_err++; $display("FAIL arst_bit5: got o_en=%b o=%b want 1 %b", o_en, o, lw[W-1-5]);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, o_en, o, in_ready} !== 5'b00000) begin
            n_err++; $display("FAIL arst_immediate: got %b want 00000", {busy, done, o_en, o, in_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, o_en, o, in_ready} !== 5'b00000) begin
            n_err++; $display("FAIL arst_held: got %b want 00000", {busy, done, o_en, o, in_ready});
        end
        @(posedge clk); #1 rst = 1'b1;
        clear_hold(12); model(8'h81, 1'b1, -1, 12);
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, 8'h81, 1'b1, 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL arst_post c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[2]) got = {got[W-2:0], obs[1]};
        end
        n_chk++;
        if (got !== 8'h81) begin
            n_err++; $display("FAIL arst_post_word: got %h want 81", got);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] obs; logic [4:0] e1[$]; int t, nv, t8, t9;
        t = 0; nv = 0; t8 = -1; t9 = -1;
        clear_hold(12); model(8'hC3, 1'b1, -1, 10); e1 = exp_q;
        model(8'h5A, 1'b1, -1, 12);
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, (c == 0) ? 8'hC3 : 8'h5A, 1'b1, 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== e1[c]) begin
                n_err++; $display("FAIL b2b_first c%0d: got %b want %b", c, obs, e1[c]);
            end
            if (obs[2]) begin nv++; if (nv == 8) t8 = t; end
            t++;
        end
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, 8'h5A, 1'b1, 1'b0, 1'b0, obs);
            n_chk++;
            if (obs !== exp_q[c]) begin
                n_err++; $display("FAIL b2b_second c%0d: got %b want %b", c, obs, exp_q[c]);
            end
            if (obs[2]) begin nv++; if (nv == 9) t9 = t; end
            t++;
        end
        n_chk++;
        if (t9 - t8 - 1 != 2 || nv != 16) begin
            n_err++; $display("FAIL b2b_gap: got gap %0d bits %0d want gap 2 bits 16", t9 - t8 - 1, nv);
        end
    endtask

    task automatic test_random;
        logic [4:0] obs; logic [W-1:0] word; logic msb; int ab; int n;
        n = 3 * int'(W) + 4;
        for (int f = 0; f < 20; f++) begin
            word = W'($urandom);
            msb  = 1'($urandom);
            clear_hold(n);
            for (int c = 0; c < 2 * int'(W); c++) hold_q[c] = ($urandom_range(3) == 0);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(int'(W) + 1, 1)) : -1;
            model(word, msb, ab, n);
            for (int c = 0; c < n; c++) begin
                cyc(c == 0, (c == 0) ? word : W'($urandom), (c == 0) ? msb : 1'($urandom),
                    hold_q[c], c == ab, obs);
                n_chk++;
                if (obs !== exp_q[c]) begin
                    n_err++; $display("FAIL random f%0d c%0d: got %b want %b", f, c, obs, exp_q[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_hold();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion before 500000");
        $fatal(1, "timeout");
    end

endmodule
